// File: rtl/pixel_coord_packer.sv
// Tags a raster-ordered 12-bit pixel stream with its (x,y) coordinate and emits
// {y, x, pix} words through a 2-entry registered output buffer (valid/ready).
module pixel_coord_packer #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sof,
    input  logic [11:0] pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [33:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        frame_done,
    output logic        sof_err
);

    localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
    localparam logic [10:0] Y_LAST = 11'(IMG_H - 1);

    typedef enum logic {
        WAIT_SOF,
        STREAM
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] x_cnt_q, x_cnt_d;
    logic [10:0] y_cnt_q, y_cnt_d;
    logic [33:0] head_q, head_d;
    logic        head_vld_q, head_vld_d;
    logic [33:0] skid_q, skid_d;
    logic        skid_vld_q, skid_vld_d;
    logic        pix_ready_q, pix_ready_d;
    logic        frame_done_q, frame_done_d;
    logic        sof_err_q, sof_err_d;

    logic        acc;
    logic        pop;
    logic        push;
    logic [33:0] word;
    logic        at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_SOF;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            head_q       <= '0;
            head_vld_q   <= 1'b0;
            skid_vld_q   <= 1'b0;
            pix_ready_q  <= 1'b1;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            head_q       <= head_d;
            head_vld_q   <= head_vld_d;
            skid_vld_q   <= skid_vld_d;
            pix_ready_q  <= pix_ready_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    // Second-entry payload is qualified by skid_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    always_comb begin
        acc          = pix_valid && pix_ready_q;
        pop          = head_vld_q && data_ready;
        at_last      = (x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST);
        state_d      = state_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;
        push         = 1'b0;
        word         = '0;

        if (acc) begin
            if (sof) begin
                // A sof pixel always starts a new frame at (0,0); mid-frame it is an
                // error unless it coincides with the last pixel of the current frame.
                push    = 1'b1;
                word    = {22'd0, pix_in};
                x_cnt_d = 11'd1;
                y_cnt_d = '0;
                state_d = STREAM;
                if (state_q == STREAM) begin
                    if (at_last) begin
                        frame_done_d = 1'b1;
                    end else begin
                        sof_err_d = 1'b1;
                    end
                end
            end else if (state_q == STREAM) begin
                push = 1'b1;
                word = {y_cnt_q, x_cnt_q, pix_in};
                if (x_cnt_q == X_LAST) begin
                    x_cnt_d = '0;
                    if (y_cnt_q == Y_LAST) begin
                        y_cnt_d      = '0;
                        frame_done_d = 1'b1;
                        state_d      = WAIT_SOF;
                    end else begin
                        y_cnt_d = y_cnt_q + 11'd1;
                    end
                end else begin
                    x_cnt_d = x_cnt_q + 11'd1;
                end
            end
        end
    end

    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;

        case ({push, pop})
            2'b10: begin
                if (!head_vld_q) begin
                    head_d     = word;
                    head_vld_d = 1'b1;
                end else begin
                    skid_d     = word;
                    skid_vld_d = 1'b1;
                end
            end
            2'b01: begin
                if (skid_vld_q) begin
                    head_d     = skid_q;
                    skid_vld_d = 1'b0;
                end else begin
                    head_vld_d = 1'b0;
                end
            end
            // Push only happens below two entries, so push+pop means one entry in flight.
            2'b11: begin
                head_d = word;
            end
            default: begin
            end
        endcase

        pix_ready_d = !(head_vld_d && skid_vld_d);
    end

    assign pix_ready  = pix_ready_q;
    assign data_out   = head_q;
    assign data_valid = head_vld_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;

endmodule
